// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Defines the queue entry bundle, the fetch FSM states and the instruction size.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for both the request PC tags and the entry queue.
// Ports: clock, reset, push/push_data, pop, flush -> head, full, empty, count.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush)
            assert (!(push && full && !do_pop))
            else $error("fetch_fifo: push into full FIFO");
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues imem requests, queues responses for decode.
// Ports: clock/reset, imem_req_*, imem_resp_*, instr_valid/instr/pcQ/pcPlus4/instr_ready,
// redirect_valid/redirect_pc; perf_* counters only when FETCH_PERF_CNT_EN is defined.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pcQ,
    output logic [31:0] pcPlus4,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam int EW = $bits(fetch_entry_t);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] drop;
    logic [CW-1:0] inflight;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] redirect_drop;
    logic [CW:0]   used;
    logic          req_fire;
    logic          deq;
    logic          push_q;
    logic [31:0]   tag_head;
    logic          q_empty;
    logic [EW-1:0] q_head_bits;
    fetch_entry_t  q_head;
    fetch_entry_t  q_push;
    logic          tag_full;
    logic          tag_empty;
    logic          q_full;
    logic          unused_bits;

    // Requests are limited by credits: queued plus in-flight never exceeds DEPTH.
    assign used           = {1'b0, occupancy} + {1'b0, inflight};
    assign imem_req_valid = !reset && (state == RUN) && !redirect_valid
                            && (used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = !q_empty;
    assign deq         = instr_valid && instr_ready;
    assign push_q      = imem_resp_valid && (drop == '0);
    assign q_head      = fetch_entry_t'(q_head_bits);
    assign q_push      = '{pc: tag_head, instr: imem_resp_data};

    assign instr   = instr_valid ? q_head.instr : '0;
    assign pcQ     = instr_valid ? q_head.pc : '0;
    assign pcPlus4 = instr_valid ? q_head.pc + 32'(INSTR_BYTES) : '0;

    // A response landing on the redirect edge is already accounted for.
    assign redirect_drop = inflight - {{(CW-1){1'b0}}, imem_resp_valid};

    assign unused_bits = ^{tag_full, tag_empty, q_full, redirect_pc[1:0]};

    // The tag FIFO count doubles as the in-flight request counter.
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (imem_resp_valid),
        .flush     (1'b0),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (inflight)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_entry_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_q),
        .push_data (q_push),
        .pop       (deq),
        .flush     (redirect_valid),
        .head      (q_head_bits),
        .full      (q_full),
        .empty     (q_empty),
        .count     (occupancy)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            drop     <= redirect_drop;
            state    <= (redirect_drop != '0) ? FLUSH : RUN;
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            if (imem_resp_valid && (drop != '0))
                drop <= drop - 1'b1;
            if ((state == FLUSH) && (drop == '0))
                state <= RUN;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
            perf_stall     <= '0;
        end else begin
            if (deq)
                perf_fetched <= perf_fetched + 1'b1;
            if (redirect_valid)
                perf_redirects <= perf_redirects + 1'b1;
            if (instr_ready && !instr_valid)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`else
    // Counters are absent in this build.
`endif

endmodule
